// File: rtl/spi_host_mode0.sv
// spi_host_mode0 -- SPI mode-0 host (CPOL=0, CPHA=0), one byte per transaction.
//
// Bytes arrive on a valid/ready interface and are shifted out MSB first on
// spi_mosi while spi_miso is shifted into the receive register. Each completed
// byte is presented on rx_data with a one-cycle rx_valid pulse. With hold_cs
// set at accept time, a byte offered in the final cycle of the current byte
// continues the transfer without releasing spi_cs (seamless burst).
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       asynchronous active-high reset (aborts any transfer)
//   tx_data   byte to send, MSB first
//   tx_valid  tx_data valid
//   tx_ready  byte accepted on the edge where tx_valid & tx_ready
//   hold_cs   sampled at accept: keep spi_cs low for a directly following byte
//   rx_data   last received byte, stable until the next rx_valid
//   rx_valid  one-cycle pulse when rx_data updates
//   busy      high from accept until the return to IDLE
//   spi_cs    chip select, high = deselected
//   spi_sclk  SPI clock, idles low
//   spi_mosi  host data out, changes on falling SCLK
//   spi_miso  device data in, asynchronous to clk (synchronised internally)
//
// CLK_DIV: clk cycles per SCLK half-period (4..255); every state lasts CLK_DIV cycles.
module spi_host_mode0 #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       hold_cs,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_cs,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [6:0] tx_shift;   // remaining bits after the MSB already on spi_mosi
    logic [7:0] rx_shift;
    logic       hold_cs_q;
    logic       miso_s1;
    logic       miso_s2;
    logic       div_end;
    logic       byte_end;
    logic       accept;

    assign div_end  = (div_cnt == DIV_LAST);
    // Final cycle of the last SCLK-high phase: the 8th falling edge follows.
    assign byte_end = (state == HIGH) && div_end && (bit_cnt == 3'd7);
    assign accept   = tx_valid && tx_ready;

    // Next-state and ready decode
    always_comb begin
        state_next = state;
        tx_ready   = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) state_next = LEAD;
            end
            LEAD, LOW: begin
                if (div_end) state_next = HIGH;
            end
            HIGH: begin
                // Burst continuation is only offered when chip select is being held
                tx_ready = byte_end && hold_cs_q;
                if (div_end) begin
                    if (bit_cnt != 3'd7)             state_next = LOW;
                    else if (hold_cs_q && tx_valid)  state_next = LEAD;
                    else                             state_next = TRAIL;
                end
            end
            TRAIL: begin
                if (div_end) state_next = GAP;
            end
            GAP: begin
                if (div_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // spi_miso two-flop synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= spi_miso;
            miso_s2 <= miso_s1;
        end
    end

    // Datapath and registered SPI outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            hold_cs_q <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            spi_cs    <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            div_cnt  <= ((state_next != state) || (state == IDLE)) ? '0 : div_cnt + 8'd1;

            case (state)
                LEAD, LOW: begin
                    if (div_end) begin
                        spi_sclk <= 1'b1;
                        rx_shift <= {rx_shift[6:0], miso_s2};
                    end
                end
                HIGH: begin
                    if (div_end) begin
                        spi_sclk <= 1'b0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            spi_mosi <= 1'b0;
                        end else begin
                            spi_mosi <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                        end
                    end
                end
                TRAIL: begin
                    if (div_end) spi_cs <= 1'b1;
                end
                GAP: begin
                    if (div_end) busy <= 1'b0;
                end
                default: ;
            endcase

            // Accept from IDLE or at byte end; placed last so a burst accept
            // overrides the idle-low mosi of the byte-end branch above.
            if (accept) begin
                tx_shift  <= tx_data[6:0];
                hold_cs_q <= hold_cs;
                bit_cnt   <= '0;
                spi_cs    <= 1'b0;
                spi_mosi  <= tx_data[7];
                busy      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_host_mode0.sv
// tb_spi_host_mode0 -- self-checking bench for spi_host_mode0 (CLK_DIV=4).
// Includes a mode-0 slave model that returns a configured byte or, in echo
// mode, the last byte it received.
module tb_spi_host_mode0;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       hold_cs;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       spi_cs;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    spi_host_mode0 #(.CLK_DIV(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .hold_cs  (hold_cs),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .spi_cs   (spi_cs),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor: captured mosi at each rising SCLK, and SCLK rising while deselected
    int unsigned rise_cnt  = 0;
    logic [15:0] mosi_cap  = '0;
    int          sclk_bad  = 0;
    always @(posedge spi_sclk) begin
        rise_cnt++;
        mosi_cap = {mosi_cap[14:0], spi_mosi};
        if (spi_cs) sclk_bad++;
    end

    // Mode-0 slave model
    logic [7:0] resp_cfg  = '0;
    bit         echo      = 1'b0;
    logic [7:0] slv_tx    = '0;
    logic [7:0] slv_rx    = '0;
    logic [7:0] echo_byte = '0;
    int         slv_bits  = 0;
    logic       cs_prev   = 1'b1;
    logic       sclk_prev = 1'b0;
    always @(spi_cs or spi_sclk) begin
        if (spi_cs !== cs_prev) begin
            slv_bits = 0;
            if (spi_cs === 1'b0) slv_tx = echo ? echo_byte : resp_cfg;
        end else if (spi_cs === 1'b0 && spi_sclk === 1'b1 && sclk_prev === 1'b0) begin
            slv_rx = {slv_rx[6:0], spi_mosi};
            slv_bits++;
        end else if (spi_cs === 1'b0 && spi_sclk === 1'b0 && sclk_prev === 1'b1) begin
            if (slv_bits == 8) begin
                slv_bits  = 0;
                echo_byte = slv_rx;
                slv_tx    = echo ? slv_rx : resp_cfg;
            end else begin
                slv_tx = {slv_tx[6:0], 1'b0};
            end
        end
        cs_prev   = spi_cs;
        sclk_prev = spi_sclk;
    end
    assign spi_miso = slv_tx[7];

    task automatic wait_ready(input string name);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, 32'(tx_ready), 32'd1);
    endtask

    // Single non-held byte with full timing checks; t counts negedges after the accept edge
    task automatic single_xfer(input string name, input logic [7:0] tx,
                               input logic [7:0] exp_rx, input logic [7:0] exp_mosi);
        int unsigned rise0;
        int   cs_hi_t = 0;
        int   rdy_t   = 0;
        int   rv_t    = 0;
        int   rv_n    = 0;
        logic [7:0] rv_data = '0;
        wait_ready(name);
        tx_data  = tx;
        tx_valid = 1'b1;
        hold_cs  = 1'b0;
        @(posedge clk);
        rise0 = rise_cnt;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~tx;
        chk({name, "_lead_cs"},    32'(spi_cs),   32'd0);
        chk({name, "_lead_sclk"},  32'(spi_sclk), 32'd0);
        chk({name, "_lead_mosi"},  32'(spi_mosi), 32'(tx[7]));
        chk({name, "_lead_busy"},  32'(busy),     32'd1);
        chk({name, "_lead_ready"}, 32'(tx_ready), 32'd0);
        for (int t = 1; t <= 18*D + 2; t++) begin
            if (t > 1) @(negedge clk);
            if (spi_cs && cs_hi_t == 0) cs_hi_t = t;
            if (tx_ready && rdy_t == 0) rdy_t = t;
            if (rx_valid) begin
                rv_n++;
                rv_t    = t;
                rv_data = rx_data;
            end
        end
        chk({name, "_rv_count"}, 32'(rv_n),             32'd1);
        chk({name, "_rv_time"},  32'(rv_t),             32'(16*D + 1));
        chk({name, "_rx_data"},  32'(rv_data),          32'(exp_rx));
        chk({name, "_cs_rise"},  32'(cs_hi_t),          32'(17*D + 1));
        chk({name, "_ready_t"},  32'(rdy_t),            32'(18*D + 1));
        chk({name, "_rises"},    32'(rise_cnt - rise0), 32'd8);
        chk({name, "_mosi"},     32'(mosi_cap[7:0]),    32'(exp_mosi));
        chk({name, "_busy_end"}, 32'(busy),             32'd0);
        chk({name, "_rx_hold"},  32'(rx_data),          32'(exp_rx));
    endtask

    task automatic burst_test();
        int unsigned rise0;
        int   acc_n   = 0;
        int   acc_t   = 0;
        int   cs_hi_t = 0;
        int   rv_n    = 0;
        int   rv_t[2] = '{0, 0};
        logic [7:0] rv_d[2] = '{8'h00, 8'h00};
        bit   drop    = 1'b0;
        resp_cfg = 8'h96;
        wait_ready("burst");
        tx_data  = 8'h01;
        hold_cs  = 1'b1;
        tx_valid = 1'b1;
        @(posedge clk);
        rise0 = rise_cnt;
        @(negedge clk);
        tx_data = 8'hFF;
        hold_cs = 1'b0;
        for (int t = 1; t <= 34*D + 2; t++) begin
            if (t > 1) @(negedge clk);
            if (drop) begin
                tx_valid = 1'b0;
                drop     = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                acc_n++;
                acc_t = t;
                drop  = 1'b1;
            end
            if (spi_cs && cs_hi_t == 0) cs_hi_t = t;
            if (rx_valid) begin
                if (rv_n < 2) begin
                    rv_t[rv_n] = t;
                    rv_d[rv_n] = rx_data;
                end
                rv_n++;
            end
        end
        tx_valid = 1'b0;
        chk("burst_accepts",  32'(acc_n),             32'd1);
        chk("burst_accept_t", 32'(acc_t),             32'(16*D));
        chk("burst_rv_count", 32'(rv_n),              32'd2);
        chk("burst_rv0_t",    32'(rv_t[0]),           32'(16*D + 1));
        chk("burst_rv_gap",   32'(rv_t[1] - rv_t[0]), 32'(16*D));
        chk("burst_rx0",      32'(rv_d[0]),           32'h96);
        chk("burst_rx1",      32'(rv_d[1]),           32'h96);
        chk("burst_cs_rise",  32'(cs_hi_t),           32'(33*D + 1));
        chk("burst_rises",    32'(rise_cnt - rise0),  32'd16);
        chk("burst_mosi",     32'(mosi_cap),          32'h01FF);
        chk("burst_ready",    32'(tx_ready),          32'd1);
        chk("burst_busy",     32'(busy),              32'd0);
    endtask

    // Two bytes without hold_cs, tx_valid held throughout; tx_data changes while busy
    task automatic b2b_test();
        int unsigned rise0;
        int   acc_n  = 0;
        int   acc_t  = 0;
        int   cs_gap = 0;
        int   rv_n   = 0;
        logic [7:0] rv_last = '0;
        bit   drop   = 1'b0;
        resp_cfg = 8'h5C;
        wait_ready("b2b");
        tx_data  = 8'h33;
        hold_cs  = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        rise0 = rise_cnt;
        @(negedge clk);
        tx_data = 8'hCC;
        for (int t = 1; t <= 36*D + 4; t++) begin
            if (t > 1) @(negedge clk);
            if (drop) begin
                tx_valid = 1'b0;
                drop     = 1'b0;
            end
            if (acc_n == 0 && spi_cs) cs_gap++;
            if (tx_valid && tx_ready) begin
                acc_n++;
                acc_t = t;
                drop  = 1'b1;
            end
            if (rx_valid) begin
                rv_n++;
                rv_last = rx_data;
            end
        end
        tx_valid = 1'b0;
        chk("b2b_accepts",  32'(acc_n),            32'd1);
        chk("b2b_accept_t", 32'(acc_t),            32'(18*D + 1));
        // GAP state plus the IDLE cycle in which the held byte is accepted
        chk("b2b_cs_gap",   32'(cs_gap),           32'(D + 1));
        chk("b2b_rv_count", 32'(rv_n),             32'd2);
        chk("b2b_rx",       32'(rv_last),          32'h5C);
        chk("b2b_rises",    32'(rise_cnt - rise0), 32'd16);
        chk("b2b_mosi",     32'(mosi_cap),         32'h33CC);
        chk("b2b_ready",    32'(tx_ready),         32'd1);
    endtask

    task automatic reset_mid_test();
        int unsigned rise0;
        int n    = 0;
        int rv_n = 0;
        resp_cfg = 8'hE7;
        wait_ready("rstmid");
        tx_data  = 8'hC3;
        hold_cs  = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        rise0 = rise_cnt;
        @(negedge clk);
        tx_valid = 1'b0;
        while ((rise_cnt - rise0) < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_rise3",    32'(rise_cnt - rise0), 32'd3);
        chk("rstmid_pre_sclk", 32'(spi_sclk),         32'd1);
        chk("rstmid_pre_cs",   32'(spi_cs),           32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_cs",       32'(spi_cs),   32'd1);
        chk("rstmid_sclk",     32'(spi_sclk), 32'd0);
        chk("rstmid_mosi",     32'(spi_mosi), 32'd0);
        chk("rstmid_busy",     32'(busy),     32'd0);
        chk("rstmid_rx_valid", 32'(rx_valid), 32'd0);
        chk("rstmid_ready",    32'(tx_ready), 32'd1);
        chk("rstmid_rx_data",  32'(rx_data),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 20*D; t++) begin
            @(negedge clk);
            if (rx_valid) rv_n++;
        end
        chk("rstmid_no_rv",   32'(rv_n),   32'd0);
        chk("rstmid_cs_idle", 32'(spi_cs), 32'd1);
        resp_cfg = 8'h69;
        single_xfer("rst_recover", 8'h5A, 8'h69, 8'h5A);
    endtask

    typedef struct {
        string      name;
        logic [7:0] tx;
        logic [7:0] resp;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs[4];

    initial begin
        rst      = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        hold_cs  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cs",       32'(spi_cs),   32'd1);
        chk("reset_sclk",     32'(spi_sclk), 32'd0);
        chk("reset_mosi",     32'(spi_mosi), 32'd0);
        chk("reset_ready",    32'(tx_ready), 32'd1);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_rx_data",  32'(rx_data),  32'd0);
        rst = 1'b0;

        vecs[0] = '{name: "xfer_a5", tx: 8'hA5, resp: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5};
        vecs[1] = '{name: "xfer_00", tx: 8'h00, resp: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00};
        vecs[2] = '{name: "xfer_ff", tx: 8'hFF, resp: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
        vecs[3] = '{name: "xfer_81", tx: 8'h81, resp: 8'h7E, exp_rx: 8'h7E, exp_mosi: 8'h81};

        for (int i = 0; i < 4; i++) begin
            resp_cfg = vecs[i].resp;
            single_xfer(vecs[i].name, vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_mosi);
        end

        burst_test();
        b2b_test();
        reset_mid_test();

        // Echo slave returns the previous byte it received (0x5A from the recovery transfer)
        echo = 1'b1;
        single_xfer("echo_1", 8'h42, 8'h5A, 8'h42);
        single_xfer("echo_2", 8'h00, 8'h42, 8'h00);

        chk("sclk_while_deselected", 32'(sclk_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

endmodule
